mul4_fitness_sequencer: RTL and testbench

Evaluation controller for one evolved 16-lane bit-sliced 2x2-bit multiplier candidate. The candidate takes inputs a1/a0/b1/b0 and produces outputs y3..y0, each 16 bits. The controller runs the candidate through 16 rounds of rotated exhaustive operand patterns, so every lane sees all 16 operand combinations once. It checks the outputs against the golden product and accumulates bit-level and lane-level fitness scores for the tournament-selection host. It sits between the host handshake and the combinational candidate under test.

---
 rtl/mul4_eval_pkg.sv | 28 ++
 rtl/mul4_lane_checker.sv | 50 +++++
 rtl/mul4_fitness_sequencer.sv | 174 +++++++++++++++++
 tb/tb_mul4_fitness_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul4_eval_pkg.sv
// Shared definitions for the 2x2-bit multiplier fitness evaluator.
//   - FSM state encoding for the sequencer
//   - lane/round/product geometry and score limits
//   - golden_prod(): reference 2x2 -> 4-bit unsigned product
package mul4_eval_pkg;

    localparam int LANES          = 16;
    localparam int ROUNDS         = 16;
    localparam int PROD_W         = 4;
    localparam int MAX_BIT_SCORE  = 1024;  // 16 rounds * 16 lanes * 4 bits
    localparam int MAX_LANE_SCORE = 256;   // 16 rounds * 16 lanes
    localparam int BIT_CNT_W      = 7;     // per-round matching bits, 0..64
    localparam int LANE_CNT_W     = 5;     // per-round matching lanes, 0..16

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_SETTLE_W,
        S_SAMPLE,
        S_DONE
    } state_e;

    function automatic logic [PROD_W-1:0] golden_prod(input logic [1:0] a,
                                                      input logic [1:0] b);
        return {2'b00, a} * {2'b00, b};
    endfunction

endpackage

// File: rtl/mul4_lane_checker.sv
// Combinational scorer for one evaluation round.
// Compares each lane's candidate result {y3,y2,y1,y0} against the golden
// product of its operands {a1,a0} * {b1,b0}.
// Ports:
//   a1,a0,b1,b0  per-lane operand bits presented to the candidate
//   y3..y0       per-lane candidate product bits
//   bit_cnt      number of matching product bits this round (0..64)
//   lane_cnt     number of lanes whose full 4-bit result matches (0..16)
module mul4_lane_checker
    import mul4_eval_pkg::*;
(
    input  logic [LANES-1:0]      a1,
    input  logic [LANES-1:0]      a0,
    input  logic [LANES-1:0]      b1,
    input  logic [LANES-1:0]      b0,
    input  logic [LANES-1:0]      y3,
    input  logic [LANES-1:0]      y2,
    input  logic [LANES-1:0]      y1,
    input  logic [LANES-1:0]      y0,
    output logic [BIT_CNT_W-1:0]  bit_cnt,
    output logic [LANE_CNT_W-1:0] lane_cnt
);

    logic [LANES-1:0][2:0] lane_bits;  // matching bits per lane, 0..4
    logic [LANES-1:0]      lane_ok;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [PROD_W-1:0] p;
        logic [PROD_W-1:0] y;
        logic [PROD_W-1:0] m;

        assign p = golden_prod({a1[i], a0[i]}, {b1[i], b0[i]});
        assign y = {y3[i], y2[i], y1[i], y0[i]};
        assign m = ~(y ^ p);

        assign lane_bits[i] = 3'(m[0]) + 3'(m[1]) + 3'(m[2]) + 3'(m[3]);
        assign lane_ok[i]   = &m;
    end

    // Linear sum as written; synthesis rebalances it into a tree.
    always_comb begin
        bit_cnt  = '0;
        lane_cnt = '0;
        for (int i = 0; i < LANES; i++) begin
            bit_cnt  = bit_cnt + BIT_CNT_W'(lane_bits[i]);
            lane_cnt = lane_cnt + LANE_CNT_W'(lane_ok[i]);
        end
    end

endmodule

// File: rtl/mul4_fitness_sequencer.sv
// Fitness evaluation controller for a 16-lane bit-sliced 2x2 multiplier
// candidate. Runs 16 rounds of rotated exhaustive operand patterns so that
// every lane sees all 16 operand combinations, and accumulates bit-level and
// lane-level match scores.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   start_i                 begin evaluation (honoured only in IDLE)
//   abort_i                 cancel a running evaluation
//   a1_o,a0_o,b1_o,b0_o     operand bits per lane, to the candidate
//   y3_i..y0_i              candidate product bits per lane
//   busy_o                  evaluation in progress
//   done_o                  one-cycle pulse when scores are final
//   bit_score_o             matching product bits, 0..1024
//   lane_score_o            fully correct lane results, 0..256
//   perfect_o               bit_score_o reached 1024 on the last run
module mul4_fitness_sequencer #(
    parameter int SETTLE = 1,   // cycles from driving operands to sampling y, >= 1
    parameter int LANES  = 16   // fixed: the pattern encoding assumes 16 lanes
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             abort_i,
    output logic [LANES-1:0] a1_o,
    output logic [LANES-1:0] a0_o,
    output logic [LANES-1:0] b1_o,
    output logic [LANES-1:0] b0_o,
    input  logic [LANES-1:0] y3_i,
    input  logic [LANES-1:0] y2_i,
    input  logic [LANES-1:0] y1_i,
    input  logic [LANES-1:0] y0_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [10:0]      bit_score_o,
    output logic [8:0]       lane_score_o,
    output logic             perfect_o
);
    import mul4_eval_pkg::*;

    localparam int WCW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    state_e                 state;
    logic [3:0]             round;
    logic [WCW-1:0]         wcnt;

    logic [LANES-1:0]       pat_a1, pat_a0, pat_b1, pat_b0;
    logic [3:0]             c;
    logic [BIT_CNT_W-1:0]   rnd_bit_cnt;
    logic [LANE_CNT_W-1:0]  rnd_lane_cnt;

    // Lane i in round r is driven with operand code (i + r) mod 16, so over
    // 16 rounds each lane walks through every {a1,a0,b1,b0} combination.
    always_comb begin
        pat_a1 = '0;
        pat_a0 = '0;
        pat_b1 = '0;
        pat_b0 = '0;
        c      = '0;
        for (int i = 0; i < LANES; i++) begin
            c         = 4'(i) + round;
            pat_a1[i] = c[3];
            pat_a0[i] = c[2];
            pat_b1[i] = c[1];
            pat_b0[i] = c[0];
        end
    end

    // Scores the registered operands against what the candidate returns.
    mul4_lane_checker u_checker (
        .a1       (a1_o),
        .a0       (a0_o),
        .b1       (b1_o),
        .b0       (b0_o),
        .y3       (y3_i),
        .y2       (y2_i),
        .y1       (y1_i),
        .y0       (y0_i),
        .bit_cnt  (rnd_bit_cnt),
        .lane_cnt (rnd_lane_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            round        <= '0;
            wcnt         <= '0;
            a1_o         <= '0;
            a0_o         <= '0;
            b1_o         <= '0;
            b0_o         <= '0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            bit_score_o  <= '0;
            lane_score_o <= '0;
            perfect_o    <= 1'b0;
        end else begin
            done_o <= 1'b0;
            // Abort wins over everything else, including the final SAMPLE
            // and the DONE cycle, so a cancelled run never reports.
            if (abort_i && (state != S_IDLE)) begin
                state        <= S_IDLE;
                round        <= '0;
                wcnt         <= '0;
                a1_o         <= '0;
                a0_o         <= '0;
                b1_o         <= '0;
                b0_o         <= '0;
                busy_o       <= 1'b0;
                bit_score_o  <= '0;
                lane_score_o <= '0;
                perfect_o    <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start_i) begin
                            bit_score_o  <= '0;
                            lane_score_o <= '0;
                            perfect_o    <= 1'b0;
                            round        <= '0;
                            busy_o       <= 1'b1;
                            state        <= S_DRIVE;
                        end
                    end
                    S_DRIVE: begin
                        a1_o <= pat_a1;
                        a0_o <= pat_a0;
                        b1_o <= pat_b1;
                        b0_o <= pat_b0;
                        // With SETTLE=1 the sample happens right after the
                        // drive cycle; otherwise hold SETTLE-1 extra cycles.
                        if (SETTLE == 1) begin
                            state <= S_SAMPLE;
                        end else begin
                            wcnt  <= WCW'(SETTLE - 1);
                            state <= S_SETTLE_W;
                        end
                    end
                    S_SETTLE_W: begin
                        if (wcnt <= WCW'(1)) begin
                            wcnt  <= '0;
                            state <= S_SAMPLE;
                        end else begin
                            wcnt <= wcnt - 1'b1;
                        end
                    end
                    S_SAMPLE: begin
                        // Maxima are 1024 and 256, so these widths never wrap.
                        bit_score_o  <= bit_score_o + 11'(rnd_bit_cnt);
                        lane_score_o <= lane_score_o + 9'(rnd_lane_cnt);
                        if (round == 4'(ROUNDS - 1)) begin
                            state <= S_DONE;
                        end else begin
                            round <= round + 1'b1;
                            state <= S_DRIVE;
                        end
                    end
                    S_DONE: begin
                        done_o    <= 1'b1;
                        busy_o    <= 1'b0;
                        perfect_o <= (bit_score_o == 11'(MAX_BIT_SCORE));
                        a1_o      <= '0;
                        a0_o      <= '0;
                        b1_o      <= '0;
                        b0_o      <= '0;
                        round     <= '0;
                        state     <= S_IDLE;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mul4_fitness_sequencer.sv
// Self-checking bench for mul4_fitness_sequencer. Two instances: one with
// SETTLE=1 whose candidate is selectable (ideal / zero / all-ones / 2-stage
// pipelined ideal), one with SETTLE=3 driven by a 2-stage pipelined ideal.
// Expected results are queued at start and checked when done_o appears.
module tb_mul4_fitness_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start_i = 1'b0, abort_i = 1'b0;
    logic        start3 = 1'b0, abort3 = 1'b0;
    logic [15:0] a1, a0, b1, b0, y3, y2, y1, y0;
    logic [15:0] a1_3, a0_3, b1_3, b0_3, y3_3, y2_3, y1_3, y0_3;
    logic        busy, done, perfect, busy3, done3, perfect3;
    logic [10:0] bits, bits3;
    logic [8:0]  lanes, lanes3;

    int mode = 0;   // 0 ideal, 1 y=0, 2 y=all ones, 3 pipelined ideal
    int cyc = 0;
    int tests = 0;
    int fails = 0;

    typedef struct {
        int bits;
        int lanes;
        bit perfect;
        bit exact;   // 0: only require bits < 1024 and not perfect
        int lat;
    } exp_t;
    exp_t sbq[$];

    function automatic logic [63:0] mul_model(input logic [15:0] m1, m0, n1, n0);
        logic [63:0] r;
        int p;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            p = (2 * int'(m1[i]) + int'(m0[i])) * (2 * int'(n1[i]) + int'(n0[i]));
            r[48+i] = p[3];
            r[32+i] = p[2];
            r[16+i] = p[1];
            r[i]    = p[0];
        end
        return r;
    endfunction

    logic [63:0] s1 = '0, s2 = '0, s1_3 = '0, s2_3 = '0, ym;
    always @(posedge clk) begin
        cyc  <= cyc + 1;
        s1   <= {a1, a0, b1, b0};
        s2   <= s1;
        s1_3 <= {a1_3, a0_3, b1_3, b0_3};
        s2_3 <= s1_3;
    end

    always_comb begin
        ym = 64'h0;
        case (mode)
            0:       ym = mul_model(a1, a0, b1, b0);
            1:       ym = 64'h0;
            2:       ym = {64{1'b1}};
            default: ym = mul_model(s2[63:48], s2[47:32], s2[31:16], s2[15:0]);
        endcase
    end
    assign {y3, y2, y1, y0} = ym;
    assign {y3_3, y2_3, y1_3, y0_3} = mul_model(s2_3[63:48], s2_3[47:32], s2_3[31:16], s2_3[15:0]);

    mul4_fitness_sequencer #(.SETTLE(1), .LANES(16)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
        .a1_o(a1), .a0_o(a0), .b1_o(b1), .b0_o(b0),
        .y3_i(y3), .y2_i(y2), .y1_i(y1), .y0_i(y0),
        .busy_o(busy), .done_o(done), .bit_score_o(bits),
        .lane_score_o(lanes), .perfect_o(perfect)
    );

    mul4_fitness_sequencer #(.SETTLE(3), .LANES(16)) dut3 (
        .clk(clk), .rst_n(rst_n), .start_i(start3), .abort_i(abort3),
        .a1_o(a1_3), .a0_o(a0_3), .b1_o(b1_3), .b0_o(b0_3),
        .y3_i(y3_3), .y2_i(y2_3), .y1_i(y1_3), .y0_i(y0_3),
        .busy_o(busy3), .done_o(done3), .bit_score_o(bits3),
        .lane_score_o(lanes3), .perfect_o(perfect3)
    );

    // Pulses start for one cycle; returns the cycle count of the sampling edge.
    task automatic pulse_start(input bit use3, output int s);
        @(negedge clk);
        if (use3) start3 = 1'b1; else start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        start3  = 1'b0;
        s = cyc;
    endtask

    task automatic wait_done(input bit use3, input int s, input string name);
        exp_t e;
        bit seen;
        int lat;
        logic [10:0] gb;
        logic [8:0]  gl;
        seen = 1'b0;
        for (int n = 0; n < 300; n++) begin
            if ((use3 ? done3 : done) === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (sbq.size() == 0) begin
            tests++; fails++;
            $display("FAIL %s scoreboard empty", name);
            return;
        end
        e = sbq.pop_front();
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL %s done_o timeout after 300 cycles", name);
            return;
        end
        lat = cyc - s;
        gb  = use3 ? bits3 : bits;
        gl  = use3 ? lanes3 : lanes;
        if (lat !== e.lat) begin
            fails++; $display("FAIL %s latency got %0d want %0d", name, lat, e.lat);
        end
        tests++;
        if (e.exact) begin
            if (int'(gb) !== e.bits) begin
                fails++; $display("FAIL %s bit_score got %0d want %0d", name, gb, e.bits);
            end
            tests++;
            if (int'(gl) !== e.lanes) begin
                fails++; $display("FAIL %s lane_score got %0d want %0d", name, gl, e.lanes);
            end
            tests++;
        end else begin
            if ((gb < 11'd1024) !== 1'b1) begin
                fails++; $display("FAIL %s bit_score got %0d want <1024", name, gb);
            end
            tests++;
        end
        if ((use3 ? perfect3 : perfect) !== e.perfect) begin
            fails++; $display("FAIL %s perfect_o got %b want %b", name, (use3 ? perfect3 : perfect), e.perfect);
        end
        tests++;
        if ((use3 ? busy3 : busy) !== 1'b0) begin
            fails++; $display("FAIL %s busy_o at done got 1 want 0", name);
        end
        tests++;
        @(negedge clk);
        if ((use3 ? done3 : done) !== 1'b0) begin
            fails++; $display("FAIL %s done_o not a single pulse", name);
        end
        tests++;
        if ((use3 ? bits3 : bits) !== gb) begin
            fails++; $display("FAIL %s bit_score not held got %0d want %0d", name, (use3 ? bits3 : bits), gb);
        end
        tests++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        if ({busy, done, perfect, busy3, done3} !== 5'b0) begin
            fails++; $display("FAIL reset flags got %b want 00000", {busy, done, perfect, busy3, done3});
        end
        tests++;
        if ({bits, lanes} !== 20'h0) begin
            fails++; $display("FAIL reset scores got %0d/%0d want 0/0", bits, lanes);
        end
        tests++;
        if ({a1, a0, b1, b0} !== 64'h0) begin
            fails++; $display("FAIL reset operands got %h want 0", {a1, a0, b1, b0});
        end
        tests++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_ideal();
        int s;
        mode = 0;
        sbq.push_back('{bits: 1024, lanes: 256, perfect: 1'b1, exact: 1'b1, lat: 33});
        pulse_start(1'b0, s);
        if (busy !== 1'b1) begin
            fails++; $display("FAIL ideal busy_o after start got %b want 1", busy);
        end
        tests++;
        @(negedge clk);
        if ({a1, a0, b1, b0} !== {16'hFF00, 16'hF0F0, 16'hCCCC, 16'hAAAA}) begin
            fails++; $display("FAIL ideal round0 operands got %h want ff00f0f0ccccaaaa", {a1, a0, b1, b0});
        end
        tests++;
        repeat (2) @(negedge clk);
        if ({a1, b0} !== {16'h7F80, 16'h5555}) begin
            fails++; $display("FAIL ideal round1 a1/b0 got %h want 7f805555", {a1, b0});
        end
        tests++;
        wait_done(1'b0, s, "ideal");
        if ({a1, a0, b1, b0} !== 64'h0) begin
            fails++; $display("FAIL ideal operands after done got %h want 0", {a1, a0, b1, b0});
        end
        tests++;
    endtask

    task automatic test_const_y();
        int s;
        mode = 1;
        sbq.push_back('{bits: 800, lanes: 112, perfect: 1'b0, exact: 1'b1, lat: 33});
        pulse_start(1'b0, s);
        wait_done(1'b0, s, "y_zero");
        mode = 2;
        sbq.push_back('{bits: 224, lanes: 0, perfect: 1'b0, exact: 1'b1, lat: 33});
        pulse_start(1'b0, s);
        wait_done(1'b0, s, "y_ones");
    endtask

    task automatic test_abort();
        int s;
        bit got_done;
        mode = 0;
        pulse_start(1'b0, s);
        repeat (14) @(negedge clk);
        // Rounds 0..6 have been scored; round 7 is being driven.
        if ({bits, lanes} !== {11'd448, 9'd112}) begin
            fails++; $display("FAIL abort pre-scores got %0d/%0d want 448/112", bits, lanes);
        end
        tests++;
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        if ({busy, done} !== 2'b00) begin
            fails++; $display("FAIL abort busy/done got %b want 00", {busy, done});
        end
        tests++;
        if ({bits, lanes, a1, a0, b1, b0} !== 84'h0) begin
            fails++; $display("FAIL abort clear got %0d/%0d ops %h want 0", bits, lanes, {a1, a0, b1, b0});
        end
        tests++;
        got_done = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) got_done = 1'b1;
        end
        if (got_done) begin
            fails++; $display("FAIL abort activity after abort got 1 want 0");
        end
        tests++;
        sbq.push_back('{bits: 1024, lanes: 256, perfect: 1'b1, exact: 1'b1, lat: 33});
        pulse_start(1'b0, s);
        wait_done(1'b0, s, "after_abort");
    endtask

    task automatic test_start_mid();
        int s;
        mode = 0;
        sbq.push_back('{bits: 1024, lanes: 256, perfect: 1'b1, exact: 1'b1, lat: 33});
        pulse_start(1'b0, s);
        repeat (8) @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        wait_done(1'b0, s, "start_mid");
        repeat (3) @(negedge clk);
        if (busy !== 1'b0) begin
            fails++; $display("FAIL start_mid queued restart busy got %b want 0", busy);
        end
        tests++;
    endtask

    task automatic test_pipeline();
        int s;
        mode = 3;
        sbq.push_back('{bits: 0, lanes: 0, perfect: 1'b0, exact: 1'b0, lat: 33});
        pulse_start(1'b0, s);
        wait_done(1'b0, s, "pipe_settle1");
        sbq.push_back('{bits: 1024, lanes: 256, perfect: 1'b1, exact: 1'b1, lat: 65});
        pulse_start(1'b1, s);
        wait_done(1'b1, s, "pipe_settle3");
    endtask

    task automatic test_reset_mid();
        int s;
        bit act;
        mode = 0;
        pulse_start(1'b0, s);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        if ({busy, done, perfect} !== 3'b000) begin
            fails++; $display("FAIL reset_mid flags got %b want 000", {busy, done, perfect});
        end
        tests++;
        if ({bits, lanes, a1, a0, b1, b0} !== 84'h0) begin
            fails++; $display("FAIL reset_mid clear got %0d/%0d ops %h want 0", bits, lanes, {a1, a0, b1, b0});
        end
        tests++;
        @(negedge clk);
        rst_n = 1'b1;
        act = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) act = 1'b1;
        end
        if (act) begin
            fails++; $display("FAIL reset_mid activity after reset got 1 want 0");
        end
        tests++;
    endtask

    initial begin
        #200000;
        $display("FAIL global timeout");
        $fatal(1, "simulation time limit");
    end

    initial begin
        test_reset();
        test_ideal();
        test_const_y();
        test_abort();
        test_start_mid();
        test_pipeline();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
